// File: rtl/counter_countdown_pkg.sv
// Shared definitions for the countdown counter.
//   state_e        : run/stop state encoding (IDLE=0, RUN=1)
//   util_math_log2 : ceil(log2(value)), minimum 1, used to size the counter
package counter_countdown_pkg;

   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_e;

   // Smallest width able to hold values 0..value-1; never returns 0.
   function automatic int unsigned util_math_log2(input int unsigned value);
      int unsigned w;
      w = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            w = i + 1;
         end
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/counter_countdown_delay.sv
// Retiming pipeline for the count output.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears every stage to 0
//   din     : value to retime
//   dout    : din delayed by DELAY cycles (a plain wire when DELAY == 0)
module counter_countdown_delay #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DELAY = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DELAY == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset_n;
      assign dout = din;
   end else begin : g_stages
      logic [WIDTH-1:0] stage_q [DELAY];

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            for (int i = 0; i < int'(DELAY); i++) begin
               stage_q[i] <= '0;
            end
         end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DELAY); i++) begin
               stage_q[i] <= stage_q[i-1];
            end
         end
      end

      assign dout = stage_q[DELAY-1];
   end

endmodule

// File: rtl/counter_countdown.sv
// Loadable down-counter with run/stop control and terminal-count pulse.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   d       : period/load value (clipped to MAX-1)
//   load    : capture d into count and period
//   start   : enter RUN (from IDLE only)
//   stop    : abort to IDLE, count held (highest priority)
//   enable  : decrement qualifier while in RUN
//   reload  : 1 = auto-reload period on terminal decrement, 0 = one-shot
//   q       : count delayed by DELAY cycles
//   zero    : undelayed count == 0
//   busy    : state is RUN
//   done    : one-cycle pulse after the terminal decrement
module counter_countdown
   import counter_countdown_pkg::*;
#(
   parameter int unsigned MAX   = 16,
   parameter int unsigned WIDTH = util_math_log2(MAX),
   parameter int unsigned DELAY = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   input  logic             load,
   input  logic             start,
   input  logic             stop,
   input  logic             enable,
   input  logic             reload,
   output logic [WIDTH-1:0] q,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MAX - 1);
   // When MAX fills the whole width no value of d can be out of range.
   localparam bit NEED_CLIP = (64'(MAX) < (64'd1 << WIDTH));

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] load_val;

   always_comb begin
      load_val = d;
      if (NEED_CLIP && (32'(d) >= MAX)) begin
         load_val = TOP_VAL;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      period_d = period_q;
      done_d   = 1'b0;
      if (stop) begin
         state_d = StIdle;
      end else if (load) begin
         count_d  = load_val;
         period_d = load_val;
         // load+start in IDLE both take effect; in RUN the enable is dropped.
         if ((state_q == StIdle) && start) begin
            state_d = StRun;
         end
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_d = StRun;
               end
            end
            StRun: begin
               if (enable) begin
                  if (count_q != '0) begin
                     count_d = count_q - WIDTH'(1);
                  end else begin
                     // Terminal decrement: never wraps below zero.
                     done_d = 1'b1;
                     if (reload) begin
                        count_d = period_q;
                     end else begin
                        state_d = StIdle;
                     end
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         count_q  <= '0;
         period_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         period_q <= period_d;
         done_q   <= done_d;
      end
   end

   assign zero = (count_q == '0);
   assign busy = (state_q == StRun);
   assign done = done_q;

   counter_countdown_delay #(
      .WIDTH (WIDTH),
      .DELAY (DELAY)
   ) u_delay (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (count_q),
      .dout    (q)
   );

endmodule

// File: tb/tb_counter_countdown.sv
// Directed bench: three instances share stimulus.
//   u16 : MAX=16, DELAY=0 (main behaviour)
//   u10 : MAX=10, DELAY=0 (load clipping)
//   ud  : MAX=16, DELAY=2 (q retiming)
module tb_counter_countdown;

   logic       clock;
   logic       reset_n;
   logic [3:0] d;
   logic       load, start, stop, enable, reload;

   logic [3:0] q16, q10, qd;
   logic       zero16, busy16, done16;
   logic       zero10, busy10, done10;
   logic       zerod, busyd, doned;

   int tests;
   int fails;

   counter_countdown #(.MAX(16), .DELAY(0)) u16 (
      .clock(clock), .reset_n(reset_n), .d(d), .load(load), .start(start), .stop(stop),
      .enable(enable), .reload(reload), .q(q16), .zero(zero16), .busy(busy16), .done(done16)
   );

   counter_countdown #(.MAX(10), .DELAY(0)) u10 (
      .clock(clock), .reset_n(reset_n), .d(d), .load(load), .start(start), .stop(stop),
      .enable(enable), .reload(reload), .q(q10), .zero(zero10), .busy(busy10), .done(done10)
   );

   counter_countdown #(.MAX(16), .DELAY(2)) ud (
      .clock(clock), .reset_n(reset_n), .d(d), .load(load), .start(start), .stop(stop),
      .enable(enable), .reload(reload), .q(qd), .zero(zerod), .busy(busyd), .done(doned)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] ar_q [6];
      logic       ar_done [6];
      logic [3:0] dl_q [10];

      tests = 0;
      fails = 0;
      d = '0; load = 0; start = 0; stop = 0; enable = 0; reload = 0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      chk("rst_q", q16, 0);
      chk("rst_zero", zero16, 1);
      chk("rst_busy", busy16, 0);
      chk("rst_done", done16, 0);
      tick();
      #2 reset_n = 1'b1;

      // Reset mid-run
      load = 1; d = 4'd5;
      tick();
      chk("a_load_q", q16, 5);
      chk("a_load_busy", busy16, 0);
      load = 0; start = 1;
      tick();
      chk("a_start_busy", busy16, 1);
      start = 0; enable = 1;
      tick();
      tick();
      chk("a_run_q", q16, 3);
      enable = 0;
      #2 reset_n = 1'b0;
      #1;
      chk("a_async_q", q16, 0);
      chk("a_async_busy", busy16, 0);
      chk("a_async_zero", zero16, 1);
      chk("a_async_done", done16, 0);
      #2 reset_n = 1'b1;

      // One-shot
      load = 1; d = 4'd3;
      tick();
      load = 0; start = 1;
      tick();
      chk("b_start_busy", busy16, 1);
      chk("b_start_q", q16, 3);
      start = 0; enable = 1; reload = 0;
      tick(); chk("b_q2", q16, 2);
      tick(); chk("b_q1", q16, 1);
      tick(); chk("b_q0", q16, 0);
      chk("b_q0_busy", busy16, 1);
      chk("b_q0_done", done16, 0);
      tick();
      chk("b_term_done", done16, 1);
      chk("b_term_busy", busy16, 0);
      chk("b_term_q", q16, 0);
      // Restart in the cycle busy falls: runs from 0, next enable terminates
      start = 1; enable = 0;
      tick();
      chk("b_re_busy", busy16, 1);
      chk("b_re_done", done16, 0);
      start = 0; enable = 1;
      tick();
      chk("b_re_done2", done16, 1);
      chk("b_re_busy2", busy16, 0);
      tick();
      chk("b_idle_q", q16, 0);
      chk("b_idle_done", done16, 0);
      chk("b_idle_busy", busy16, 0);
      enable = 0;

      // Auto-reload
      load = 1; d = 4'd2;
      tick();
      load = 0; start = 1;
      tick();
      chk("c_start_q", q16, 2);
      start = 0; reload = 1; enable = 1;
      ar_q    = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
      ar_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("c_q%0d", i), q16, ar_q[i]);
         chk($sformatf("c_done%0d", i), done16, ar_done[i]);
         chk($sformatf("c_busy%0d", i), busy16, 1);
      end

      // Priority
      enable = 0; load = 1; d = 4'd4;
      tick();
      chk("d_load_q", q16, 4);
      chk("d_load_busy", busy16, 1);
      stop = 1; load = 1; d = 4'd9; enable = 1;
      tick();
      chk("d_stop_busy", busy16, 0);
      chk("d_stop_q", q16, 4);
      chk("d_stop_done", done16, 0);
      stop = 0; enable = 0; load = 1; d = 4'd9; start = 1;
      tick();
      chk("d_ldst_busy", busy16, 1);
      chk("d_ldst_q", q16, 9);
      load = 1; d = 4'd6; start = 0; enable = 1;
      tick();
      chk("d_ldrun_q", q16, 6);
      load = 0; enable = 0; stop = 1;
      tick();
      chk("d_stop2_busy", busy16, 0);
      stop = 0;

      // Clipping on MAX=10
      reload = 0; load = 1; d = 4'd13;
      tick();
      chk("e_clip_q10", q10, 9);
      chk("e_noclip_q16", q16, 13);
      load = 0; start = 1;
      tick();
      start = 0; reload = 1; enable = 1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 9) begin
            chk("e_p9_q0", q10, 0);
            chk("e_p9_done", done10, 0);
         end
         if (i == 10) begin
            chk("e_p9_reload_q", q10, 9);
            chk("e_p9_done10", done10, 1);
         end
      end
      stop = 1; enable = 0; reload = 0;
      tick();
      stop = 0; load = 1; d = 4'd0;
      tick();
      load = 0; start = 1;
      tick();
      start = 0; enable = 1;
      tick();
      chk("e_n0_done", done10, 1);
      chk("e_n0_busy", busy10, 0);
      enable = 0;

      // Delay alignment on DELAY=2
      #2 reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      dl_q = '{4'd0, 4'd0, 4'd7, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
      for (int e = 1; e <= 10; e++) begin
         load   = (e == 1);
         d      = 4'd7;
         start  = (e == 2);
         enable = (e >= 3);
         tick();
         chk($sformatf("f_qd_e%0d", e), qd, dl_q[e-1]);
         if (e == 9) chk("f_zero_e9", zerod, 1);
         if (e == 10) begin
            chk("f_done_e10", doned, 1);
            chk("f_busy_e10", busyd, 0);
         end
      end
      enable = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
